// File: rtl/serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module   : serial_magnitude_comparator (+ comparator_2bit slice)
// Brief    : MSB-first unsigned compare of two WIDTH-bit operands, 2 bits/cycle
// Revision : 1.0
// ============================================================================

module comparator_2bit (
  input  logic [1:0] a,
  input  logic [1:0] b,
  output logic       gt,
  output logic       eq,
  output logic       lt
);
  assign gt = (a > b);
  assign eq = (a == b);
  assign lt = (a < b);
endmodule

module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             busy
);
  localparam int C_NDIG  = WIDTH / 2;
  localparam int C_CNT_W = (C_NDIG > 1) ? $clog2(C_NDIG) : 1;
  localparam logic [C_CNT_W-1:0] C_CNT_INIT = C_CNT_W'(C_NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_capture;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_gt;
  logic               r_eq;
  logic               r_lt;
  logic               w_gt;
  logic               w_eq;
  logic               w_lt;

  comparator_2bit u_slice (
    .a  (r_a_sh[WIDTH-1 -: 2]),
    .b  (r_b_sh[WIDTH-1 -: 2]),
    .gt (w_gt),
    .eq (w_eq),
    .lt (w_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_COMPARE;
          w_capture   = 1'b1;
        end
      end
      S_COMPARE: begin
        if (!w_eq || (r_cnt == '0)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Flags survive the output handshake; only a new capture clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh <= '0;
      r_b_sh <= '0;
      r_cnt  <= '0;
      r_gt   <= 1'b0;
      r_eq   <= 1'b0;
      r_lt   <= 1'b0;
    end else if (w_capture) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_cnt  <= C_CNT_INIT;
      r_gt   <= 1'b0;
      r_eq   <= 1'b0;
      r_lt   <= 1'b0;
    end else if (r_state == S_COMPARE) begin
      if (w_gt) begin
        r_gt <= 1'b1;
      end else if (w_lt) begin
        r_lt <= 1'b1;
      end else if (r_cnt == '0) begin
        r_eq <= 1'b1;
      end else begin
        r_a_sh <= r_a_sh << 2;
        r_b_sh <= r_b_sh << 2;
        r_cnt  <= r_cnt - C_CNT_W'(1);
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign a_gt_b    = r_gt;
  assign a_eq_b    = r_eq;
  assign a_lt_b    = r_lt;

endmodule
`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_magnitude_comparator
// Brief    : Scoreboarded bench for WIDTH = 2, 8 and 16 comparator instances
// Revision : 1.0
// ============================================================================
module tb_serial_magnitude_comparator;

  typedef struct {
    logic [2:0] flags;   // {gt, eq, lt}
    int         lat;
    int         acc;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] flags;
    int         lat;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad   = 0;
  int   got16 = 0;
  exp_t q2[$];
  exp_t q8[$];
  exp_t q16[$];

  logic        d2_in_valid, d2_in_ready, d2_out_valid, d2_out_ready;
  logic        d2_gt, d2_eq, d2_lt, d2_busy;
  logic [1:0]  d2_a, d2_b;
  logic        d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready;
  logic        d8_gt, d8_eq, d8_lt, d8_busy;
  logic [7:0]  d8_a, d8_b;
  logic        d16_in_valid, d16_in_ready, d16_out_valid, d16_out_ready;
  logic        d16_gt, d16_eq, d16_lt, d16_busy;
  logic [15:0] d16_a, d16_b;

  serial_magnitude_comparator #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(d2_in_valid), .in_ready(d2_in_ready),
    .a(d2_a), .b(d2_b), .out_valid(d2_out_valid), .out_ready(d2_out_ready),
    .a_gt_b(d2_gt), .a_eq_b(d2_eq), .a_lt_b(d2_lt), .busy(d2_busy)
  );

  serial_magnitude_comparator #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
    .a(d8_a), .b(d8_b), .out_valid(d8_out_valid), .out_ready(d8_out_ready),
    .a_gt_b(d8_gt), .a_eq_b(d8_eq), .a_lt_b(d8_lt), .busy(d8_busy)
  );

  serial_magnitude_comparator #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
    .a(d16_a), .b(d16_b), .out_valid(d16_out_valid), .out_ready(d16_out_ready),
    .a_gt_b(d16_gt), .a_eq_b(d16_eq), .a_lt_b(d16_lt), .busy(d16_busy)
  );

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  task automatic fail_now(input string nm, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s (cycle %0d)", nm, what, cyc);
  endtask

  // Reference: integer compare for flags, MSB-first digit scan for latency.
  function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv, input int ndig);
    exp_t e;
    bit   found = 1'b0;
    e.flags = (av > bv) ? 3'b100 : ((av < bv) ? 3'b001 : 3'b010);
    e.lat   = ndig;
    e.acc   = 0;
    for (int j = 1; j <= ndig; j++) begin
      if (!found && (((av >> (2 * (ndig - j))) & 16'd3) != ((bv >> (2 * (ndig - j))) & 16'd3))) begin
        e.lat = j;
        found = 1'b1;
      end
    end
    return e;
  endfunction

  // ---------------- result monitors ----------------
  logic seen2 = 1'b0, seen8 = 1'b0, seen16 = 1'b0;

  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst_n) seen2 = 1'b0;
    else begin
      if (d2_out_valid && !seen2) begin
        seen2 = 1'b1;
        if (q2.size() == 0) fail_now("w2_spurious", "result with no pending operation");
        else begin
          e = q2.pop_front();
          chk("w2_flags", int'({d2_gt, d2_eq, d2_lt}), int'(e.flags));
          chk("w2_latency", cyc - e.acc, e.lat);
        end
      end
      if (d2_out_valid && d2_out_ready) seen2 = 1'b0;
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (!rst_n) seen8 = 1'b0;
    else begin
      if (d8_out_valid && !seen8) begin
        seen8 = 1'b1;
        if (q8.size() == 0) fail_now("w8_spurious", "result with no pending operation");
        else begin
          e = q8.pop_front();
          chk("w8_flags", int'({d8_gt, d8_eq, d8_lt}), int'(e.flags));
          chk("w8_latency", cyc - e.acc, e.lat);
        end
      end
      if (d8_out_valid && d8_out_ready) seen8 = 1'b0;
    end
  end

  always @(negedge clk) begin : mon16
    exp_t e;
    if (!rst_n) seen16 = 1'b0;
    else begin
      if (d16_out_valid && !seen16) begin
        seen16 = 1'b1;
        got16++;
        if (q16.size() == 0) fail_now("w16_spurious", "result with no pending operation");
        else begin
          e = q16.pop_front();
          chk("w16_flags", int'({d16_gt, d16_eq, d16_lt}), int'(e.flags));
          chk("w16_latency", cyc - e.acc, e.lat);
        end
      end
      if (d16_out_valid && d16_out_ready) seen16 = 1'b0;
    end
  end

  // ---------------- drivers (entered just after a rising edge) ----------------
  task automatic accept8(input logic [7:0] av, input logic [7:0] bv,
                         input logic [2:0] fl, input int lat);
    exp_t e;
    bit   ok = 1'b0;
    d8_a = av;
    d8_b = bv;
    d8_in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = d8_in_ready;
    end
    if (!ok) fail_now("w8_accept_timeout", "in_ready never rose within 50 cycles");
    else begin
      e.flags = fl;
      e.lat   = lat;
      e.acc   = cyc + 1;
      q8.push_back(e);
    end
    @(posedge clk);
    #1 d8_in_valid = 1'b0;
  endtask

  task automatic wait_valid8();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = d8_out_valid;
    end
    if (!ok) fail_now("w8_result_timeout", "out_valid never rose within 100 cycles");
  endtask

  initial begin
    d16_out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 d16_out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  vec_t vecs[8];

  initial begin
    exp_t       e;
    bit         ok;
    logic [3:0] iv;
    logic [15:0] av, bv;
    int         k;

    vecs[0] = '{8'h12, 8'h13, 3'b001, 4};
    vecs[1] = '{8'h3C, 8'h3C, 3'b010, 4};
    vecs[2] = '{8'hA5, 8'h5A, 3'b100, 1};
    vecs[3] = '{8'h80, 8'hC0, 3'b001, 1};
    vecs[4] = '{8'h00, 8'h01, 3'b001, 4};
    vecs[5] = '{8'hFF, 8'hFE, 3'b100, 4};
    vecs[6] = '{8'h37, 8'h33, 3'b100, 3};
    vecs[7] = '{8'h24, 8'h14, 3'b100, 2};

    d2_in_valid = 0; d2_a = 0; d2_b = 0; d2_out_ready = 1'b1;
    d8_in_valid = 0; d8_a = 0; d8_b = 0; d8_out_ready = 1'b1;
    d16_in_valid = 0; d16_a = 0; d16_b = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(d8_out_valid), 0);
    chk("rst_flags", int'({d8_gt, d8_eq, d8_lt}), 0);
    chk("rst_busy", int'(d8_busy), 0);
    chk("rst_w16_out_valid", int'(d16_out_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", int'(d8_in_ready), 1);
    chk("rel_busy", int'(d8_busy), 0);

    // Fast path: first digit differs, then back to IDLE one cycle after result.
    @(posedge clk); #1;
    accept8(8'hA5, 8'h5A, 3'b100, 1);
    wait_valid8();
    @(negedge clk);
    chk("a5_idle_busy", int'(d8_busy), 0);
    chk("a5_idle_in_ready", int'(d8_in_ready), 1);

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      accept8(vecs[i].a, vecs[i].b, vecs[i].flags, vecs[i].lat);
      wait_valid8();
    end

    // Backpressure hold for five cycles, handshake on the sixth edge.
    @(posedge clk); #1;
    d8_out_ready = 1'b0;
    accept8(8'hFF, 8'h00, 3'b100, 1);
    wait_valid8();
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", int'(d8_out_valid), 1);
      chk("bp_gt", int'(d8_gt), 1);
      chk("bp_in_ready", int'(d8_in_ready), 0);
      if (i == 4) d8_out_ready = 1'b1;
      @(negedge clk);
    end
    chk("bp_after_out_valid", int'(d8_out_valid), 0);
    chk("bp_after_busy", int'(d8_busy), 0);
    chk("bp_flags_held", int'({d8_gt, d8_eq, d8_lt}), 3'b100);

    // Reset mid-compare discards the operation.
    @(posedge clk); #1;
    accept8(8'h40, 8'h41, 3'b001, 4);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    q8.delete();
    #1;
    chk("mid_rst_out_valid", int'(d8_out_valid), 0);
    chk("mid_rst_flags", int'({d8_gt, d8_eq, d8_lt}), 0);
    chk("mid_rst_busy", int'(d8_busy), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    accept8(8'h01, 8'h00, 3'b100, 4);
    wait_valid8();

    // WIDTH=2: all 16 pairs, in_valid held high across operations.
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      iv = 4'(i);
      d2_a = iv[3:2];
      d2_b = iv[1:0];
      d2_in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        @(negedge clk);
        ok = d2_in_ready;
      end
      if (!ok) fail_now("w2_accept_timeout", "in_ready never rose within 20 cycles");
      else begin
        e = model(16'(d2_a), 16'(d2_b), 1);
        e.acc = cyc + 1;
        q2.push_back(e);
      end
      @(posedge clk); #1;
    end
    d2_in_valid = 1'b0;

    // WIDTH=16: random pairs biased towards long equal prefixes.
    for (int n = 0; n < 1000; n++) begin
      d16_in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      av = 16'($urandom);
      case ($urandom_range(0, 3))
        0: bv = av;
        1: bv = 16'($urandom);
        default: begin
          k  = $urandom_range(0, 7);
          bv = av ^ (16'($urandom_range(1, 3)) << (2 * k));
        end
      endcase
      d16_a = av;
      d16_b = bv;
      d16_in_valid = 1'b1;
      ok = 1'b0;
      for (int t = 0; t < 60 && !ok; t++) begin
        @(negedge clk);
        ok = d16_in_ready;
      end
      if (!ok) fail_now("w16_accept_timeout", "in_ready never rose within 60 cycles");
      else begin
        e = model(av, bv, 8);
        e.acc = cyc + 1;
        q16.push_back(e);
      end
      @(posedge clk); #1;
    end
    d16_in_valid = 1'b0;

    for (int i = 0; i < 300 && (q2.size() != 0 || q8.size() != 0 || q16.size() != 0); i++)
      @(negedge clk);
    chk("w2_pending_left", q2.size(), 0);
    chk("w8_pending_left", q8.size(), 0);
    chk("w16_pending_left", q16.size(), 0);
    chk("w16_result_count", got16, 1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
